// File: rtl/inst_rom_responder.sv
// Responder side of the instruction-fetch ROM port: byte-lane writable word array
// with optional wait states, fault detection and a registered one-cycle response.
module inst_rom_responder #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH_LOG2  = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [3:0]            rom_write_en,
    input  logic [DATA_WIDTH-1:0] rom_write_data,
    output logic [DATA_WIDTH-1:0] rom_read_data,
    output logic                  inst_valid,
    output logic                  inst_fault,
    output logic                  stall_req,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    flt_q, flt_d;
    logic [3:0]              we_q, we_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic                    stall_q, stall_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0]   cur_offset;
    logic [DEPTH_LOG2-1:0]   cur_idx;
    logic                    cur_flt;

    logic                    cpl;
    logic [DEPTH_LOG2-1:0]   cpl_idx;
    logic                    cpl_flt;
    logic [3:0]              cpl_we;
    logic [DATA_WIDTH-1:0]   cpl_wd;

    logic                    mem_wr;
    logic [DEPTH_LOG2-1:0]   mem_idx;
    logic [3:0]              mem_lanes;
    logic [DATA_WIDTH-1:0]   mem_wd;

    always_comb begin
        cur_offset = rom_addr - BASE_ADDR;
        cur_idx    = DEPTH_LOG2'(cur_offset >> 2);
        cur_flt    = (rom_addr[1:0] != 2'b00) ||
                     ((cur_offset >> (DEPTH_LOG2 + 2)) != '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        flt_d   = flt_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        valid_d = 1'b0;
        fault_d = 1'b0;

        cpl     = 1'b0;
        cpl_idx = cur_idx;
        cpl_flt = cur_flt;
        cpl_we  = rom_write_en;
        cpl_wd  = rom_write_data;

        if (state_q == S_WAIT) begin
            if (cnt_q == 4'd0) begin
                state_d = S_RESP;
                cpl     = 1'b1;
                cpl_idx = idx_q;
                cpl_flt = flt_q;
                cpl_we  = we_q;
                cpl_wd  = wd_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (WAIT_CYCLES == 0) begin
            // Zero wait states: the accept edge is also the completion edge.
            state_d = S_RESP;
            cpl     = 1'b1;
        end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            idx_d   = cur_idx;
            flt_d   = cur_flt;
            we_d    = rom_write_en;
            wd_d    = rom_write_data;
        end

        mem_wr    = 1'b0;
        mem_idx   = cpl_idx;
        mem_lanes = cpl_we;
        mem_wd    = cpl_wd;
        if (cpl) begin
            valid_d = 1'b1;
            fault_d = cpl_flt;
            rd_d    = cpl_flt ? NOP_WORD : mem[cpl_idx];
            // Gate on rst too: the array has no reset, so an edge under reset must not write.
            mem_wr  = !cpl_flt && (cpl_we != 4'b0000) && !rst;
        end

        stall_d = (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            flt_q   <= 1'b0;
            we_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            flt_q   <= flt_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_lanes[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    assign rom_read_data = rd_q;
    assign inst_valid    = valid_q;
    assign inst_fault    = fault_q;
    assign stall_req     = stall_q;
    assign busy          = busy_q;

endmodule

// File: doc/inst_rom_responder.md
Name: inst_rom_responder

Overview:
- Responder end of the instruction-fetch ROM interface: it receives the fetch address, byte-lane write enables and write data driven by the IF-stage program counter.
- It returns the instruction word plus valid/fault flags, and requests a PC stall while wait states are pending.
- It sits between the IF stage and the on-chip instruction memory array. It provides a configurable read latency so slower memories can be modelled without changing the PC.

Parameters:
- ADDR_WIDTH, 32, width of the fetch address
- DATA_WIDTH, 32, instruction/data word width
- DEPTH_LOG2, 12, log2 of the array depth in words (4096 words)
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
- WAIT_CYCLES, 0, extra wait states per access (0..15)
- NOP_WORD, 32'h0000_0013, word returned on a faulting fetch

Ports:
- clk  input  1  system clock; everything is rising-edge
- rst  input  1  asynchronous, active-high reset
- rom_addr  input  ADDR_WIDTH  fetch byte address, driven every cycle
- rom_write_en  input  4  byte-lane write enables; 0 means read-only access
- rom_write_data  input  DATA_WIDTH  write data, lane i = bits [8i+7:8i]
- rom_read_data  output  DATA_WIDTH  instruction word for the last completed access
- inst_valid  output  1  one-cycle pulse when rom_read_data carries a completed access
- inst_fault  output  1  qualifies inst_valid; the access was misaligned or out of range
- stall_req  output  1  high while an access is in wait states; feeds the PC stall
- busy  output  1  high when state is not IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wait counter=0, rom_read_data=0, inst_valid=0, inst_fault=0, stall_req=0, busy=0. Array contents are not cleared. A reset during WAIT abandons the access, and any pending write is dropped.
- Offset = rom_addr - BASE_ADDR (modulo 2^ADDR_WIDTH). Index = offset[DEPTH_LOG2+1:2].
- Faults:
  - Misaligned: rom_addr[1:0] != 0.
  - Out of range: offset >= 4 * 2^DEPTH_LOG2.
- States are IDLE, WAIT and RESP.
- Acceptance: an access is accepted on any rising edge where state is IDLE or RESP. The address, lanes and data are latched at that edge.
- WAIT_CYCLES=0:
  - The accept edge goes directly to RESP.
  - In the next cycle, rom_read_data = array[index] as it was before the edge, and inst_valid=1.
  - Back-to-back accepts sustain 1 access per cycle.
- WAIT_CYCLES=N>0:
  - The accept edge goes to WAIT and loads the counter with N-1.
  - WAIT decrements the counter each edge. When the counter is 0, the next edge moves to RESP with data and inst_valid.
  - stall_req = (state==WAIT), so stall_req is high for exactly N cycles per access.
  - While in WAIT, the inputs are ignored; the PC holds rom_addr stable because of the stall.
- RESP with no new access: IDLE is an alias for "no access outstanding". Because rom_addr is always valid, RESP accepts the current address every edge. IDLE is occupied only after reset, for one cycle.
- Read data for a faulting access: rom_read_data=NOP_WORD, inst_fault=1, inst_valid=1. A faulting access never writes the array.
- Writes (rom_write_en != 0, non-faulting):
  - At the final edge of the access (accept edge when N=0, WAIT-exit edge when N>0), the enabled byte lanes of array[index] are updated.
  - The returned read data is the pre-write word (read-before-write).
  - Disabled lanes are unchanged.
- rom_read_data holds its value when inst_valid=0. inst_valid and inst_fault are registered outputs.
- Simultaneous events: reset dominates the clock. A write and a read to the same index in consecutive accesses return the new data on the second access.
- Worst-case latency is WAIT_CYCLES+1 cycles from accept to inst_valid.

Test Plan:
1. Array preloaded with word k = 32'h1000_0000+k; WAIT_CYCLES=0; after reset, drive rom_addr 0,4,8 on consecutive edges. Required: inst_valid high 3 cycles with data 32'h1000_0000, 32'h1000_0001, 32'h1000_0002; stall_req never set.
2. WAIT_CYCLES=2; rom_addr=32'h10, same preload. Required: stall_req high exactly 2 cycles, then inst_valid=1 with data 32'h1000_0004, inst_fault=0.
3. rom_addr=32'h6 (misaligned), then 32'h4000 (out of range with DEPTH_LOG2=12). Required: both return 32'h0000_0013 with inst_fault=1, and the array is unchanged.
4. Write sequence:
   - Write rom_addr=32'h20, rom_write_en=4'b0011, rom_write_data=32'hAABB_CCDD. Required: returns old word 32'h1000_0008.
   - Read 32'h20. Required: 32'h1000_CCDD.
5. WAIT_CYCLES=3; assert rst asynchronously during the 2nd wait cycle of a write access. Required: all outputs 0 immediately, the write is not performed, and the access restarts cleanly after rst is released.
